// File: rtl/q_measure_avg_pkg.sv
// Shared types and width helpers for the Q measurement averager.
// Optional outlier filter is enabled by defining Q_OUTLIER_REJECT_EN.
package q_meas_pkg;

  localparam int BUS_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    DONE
  } state_t;

  // A zero-sample settle still needs a 1-bit counter to elaborate.
  function automatic int settle_cnt_w(int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int avg_cnt_w(int l2);
    return l2 + 1;
  endfunction

endpackage

// File: rtl/q_measure_avg_if.sv
// Sample input, reference tracking and averaged result bundle.
// Feature macro Q_OUTLIER_REJECT_EN does not change this interface.
interface q_meas_if
  import q_meas_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
);

  logic                 enable;
  logic [BUS_WIDTH-1:0] i_ref_setup;
  logic [BUS_WIDTH-1:0] q_sample;
  logic                 q_sample_valid;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 ready;

  modport master (
    output enable,
    output i_ref_setup,
    output q_sample,
    output q_sample_valid,
    input  q_measured,
    input  ready
  );

  modport slave (
    input  enable,
    input  i_ref_setup,
    input  q_sample,
    input  q_sample_valid,
    output q_measured,
    output ready
  );

endinterface

// File: rtl/q_measure_avg_accum.sv
// Accumulator and sample counter; with Q_OUTLIER_REJECT_EN defined,
// samples too far from the first accumulated one are dropped.
module q_avg_accum
  import q_meas_pkg::*;
#(
  parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
  parameter int AVG_LOG2      = 2,
  parameter int OUTLIER_DELTA = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample_en,
  input  logic [BUS_WIDTH-1:0] sample,
  output logic                 last,
  output logic [BUS_WIDTH-1:0] avg
);

  localparam int AW = BUS_WIDTH + AVG_LOG2;
  localparam int CW = avg_cnt_w(AVG_LOG2);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [CW-1:0] cnt;
  logic          take;

  assign sum  = acc + AW'(sample);
  assign avg  = sum[AW-1:AVG_LOG2];
  assign last = take && (cnt == CNT_LAST);

`ifdef Q_OUTLIER_REJECT_EN
  localparam int DW = BUS_WIDTH + 1;
  localparam logic [DW-1:0] DELTA = DW'(OUTLIER_DELTA);

  logic [BUS_WIDTH-1:0] anchor;
  logic [DW-1:0]        sa;
  logic [DW-1:0]        sb;
  logic [DW-1:0]        dist;

  assign sa   = {1'b0, sample};
  assign sb   = {1'b0, anchor};
  assign dist = (sa >= sb) ? (sa - sb) : (sb - sa);
  // The first sample of a sequence is the anchor and always taken.
  assign take = sample_en &&
                ((cnt == '0) || (dist <= DELTA));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anchor <= '0;
    end else if (clear) begin
      anchor <= '0;
    end else if (sample_en && (cnt == '0)) begin
      anchor <= sample;
    end
  end
`else
  logic unused_delta;
  assign unused_delta = (OUTLIER_DELTA != 0);
  assign take         = sample_en;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/q_measure_avg.sv
// Settle-then-average front end feeding the instability detector.
// Define Q_OUTLIER_REJECT_EN to enable anchor-based outlier rejection.
module q_measure_avg
  import q_meas_pkg::*;
#(
  parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int AVG_LOG2       = 2,
  parameter int SETTLE_SAMPLES = 4,
  parameter int OUTLIER_DELTA  = 20
) (
  input logic     clk,
  input logic     rst,
  q_meas_if.slave bus
);

  localparam int SW = settle_cnt_w(SETTLE_SAMPLES);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam state_t START =
    (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;

  state_t               state;
  state_t               state_nx;
  logic [SW-1:0]        settle_cnt;
  logic [SW-1:0]        settle_nx;
  logic [BUS_WIDTH-1:0] i_ref_last;
  logic [BUS_WIDTH-1:0] q_meas;
  logic [BUS_WIDTH-1:0] q_meas_nx;
  logic [BUS_WIDTH-1:0] avg;
  logic                 rdy;
  logic                 rdy_nx;
  logic                 change;
  logic                 clear;
  logic                 sample_en;
  logic                 last;

  assign change = (state != IDLE) &&
                  (bus.i_ref_setup != i_ref_last);

  // Change-cycle and disabled-cycle samples never reach the sum.
  assign sample_en = bus.enable && !change &&
                     (state == ACCUM) && bus.q_sample_valid;

  assign clear = (state != ACCUM) || change || !bus.enable;

  q_avg_accum #(
    .BUS_WIDTH    (BUS_WIDTH),
    .AVG_LOG2     (AVG_LOG2),
    .OUTLIER_DELTA(OUTLIER_DELTA)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .sample_en(sample_en),
    .sample   (bus.q_sample),
    .last     (last),
    .avg      (avg)
  );

  always_comb begin
    state_nx  = state;
    settle_nx = settle_cnt;
    rdy_nx    = rdy;
    q_meas_nx = q_meas;
    if (!bus.enable) begin
      state_nx  = IDLE;
      settle_nx = '0;
      rdy_nx    = 1'b0;
    end else if (change) begin
      state_nx  = START;
      settle_nx = '0;
      rdy_nx    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx  = START;
          settle_nx = '0;
        end
        SETTLE: begin
          if (bus.q_sample_valid) begin
            if (settle_cnt == SETTLE_LAST)
              state_nx = ACCUM;
            else
              settle_nx = settle_cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (last) begin
            state_nx  = DONE;
            rdy_nx    = 1'b1;
            q_meas_nx = avg;
          end
        end
        DONE: begin
          state_nx = DONE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      rdy        <= 1'b0;
      q_meas     <= '0;
      i_ref_last <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= settle_nx;
      rdy        <= rdy_nx;
      q_meas     <= q_meas_nx;
      i_ref_last <= bus.i_ref_setup;
    end
  end

  assign bus.q_measured = q_meas;
  assign bus.ready      = rdy;

endmodule

// File: tb/tb_q_measure_avg.sv
// Scoreboard bench for q_measure_avg with SETTLE_SAMPLES=2.
// Expected outlier result follows Q_OUTLIER_REJECT_EN.
module tb_q_measure_avg;

  localparam int BW = 10;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_total;
  logic prev_ready;
  exp_t sb[$];

  q_meas_if #(.BUS_WIDTH(BW)) bus ();

  q_measure_avg #(
    .BUS_WIDTH     (BW),
    .AVG_LOG2      (2),
    .SETTLE_SAMPLES(2),
    .OUTLIER_DELTA (20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %0d want %0d",
                  name, got, want);
  endtask

  // Result monitor: every rising ready must match the next entry.
  always @(negedge clk) begin
    if (bus.ready && !prev_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_value", int'(bus.q_measured), e.val);
        chk("out_cycle", cyc, e.cyc);
      end
    end
    prev_ready <= bus.ready;
  end

  task automatic drive(logic v, int s);
    bus.q_sample_valid = v;
    bus.q_sample       = BW'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(int v);
    exp_t e;
    e.val = v;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic check_now(string nm, int q, int r);
    chk({nm, "_q"}, int'(bus.q_measured), q);
    chk({nm, "_rdy"}, int'(bus.ready), r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    n_pass             = 0;
    n_total            = 0;
    prev_ready         = 1'b0;
    rst                = 1'b1;
    bus.enable         = 1'b0;
    bus.i_ref_setup    = '0;
    bus.q_sample       = '0;
    bus.q_sample_valid = 1'b0;

    @(negedge clk);
    check_now("reset_init", 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic average: 100,101 settle; (102..105)>>2 = 103.
    bus.enable      = 1'b1;
    bus.i_ref_setup = 10'd5;
    drive(0, 0);
    for (int i = 0; i < 5; i++) drive(1, 100 + i);
    expect_out(103);
    drive(1, 105);
    drive(0, 0);
    check_now("basic_hold", 103, 1);

    // Asynchronous reset between edges.
    rst = 1'b1;
    #1;
    check_now("rst_async", 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_now("rst_held", 0, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Change mid-ACCUM; the change-cycle 999 is dropped.
    drive(0, 0);
    for (int i = 0; i < 4; i++) drive(1, 100 + i);
    bus.i_ref_setup = 10'd6;
    drive(1, 999);
    check_now("chg_restart", 0, 0);
    drive(1, 200);
    drive(1, 200);
    drive(1, 210);
    drive(1, 210);
    drive(1, 220);
    expect_out(215);
    drive(1, 220);
    drive(0, 0);
    check_now("chg_done", 215, 1);

    // Change in DONE drops ready but keeps the old value.
    bus.i_ref_setup = 10'd7;
    drive(0, 0);
    check_now("done_chg", 215, 0);

    // Valid gaps: 1,0 pattern stretches but does not alter result.
    for (int i = 0; i < 5; i++) begin
      drive(1, 100 + i);
      drive(0, 0);
    end
    expect_out(103);
    drive(1, 105);
    drive(0, 0);
    drive(1, 500);
    drive(1, 600);
    drive(0, 0);
    check_now("done_ignore", 103, 1);

    // Enable drop in ACCUM, then a full re-run.
    bus.i_ref_setup = 10'd8;
    drive(0, 0);
    drive(1, 100);
    drive(1, 101);
    drive(1, 50);
    drive(1, 60);
    bus.enable = 1'b0;
    drive(1, 70);
    check_now("en_drop", 103, 0);
    bus.enable = 1'b1;
    drive(0, 0);
    for (int i = 1; i < 6; i++) drive(1, 10 * i);
    expect_out(45);
    drive(1, 60);
    drive(0, 0);
    check_now("en_rerun", 45, 1);

    // Outlier pattern after settle.
    bus.i_ref_setup = 10'd9;
    drive(0, 0);
    drive(1, 1);
    drive(1, 2);
    drive(1, 100);
    drive(1, 100);
    drive(1, 200);
`ifdef Q_OUTLIER_REJECT_EN
    drive(1, 100);
    expect_out(100);
    drive(1, 100);
    drive(0, 0);
    check_now("outlier", 100, 1);
`else
    expect_out(125);
    drive(1, 100);
    drive(1, 100);
    drive(0, 0);
    check_now("outlier", 125, 1);
`endif

    repeat (3) drive(0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/q_measure_avg.md
Name: q_measure_avg

Overview:
- Upstream stage of the instability detector.
- Turns raw per-sample Q readings into one settled, averaged q_measured value per i_ref_setup step.
- Raises ready when the value is valid; ready and q_measured drive the detector's ready and q_measured inputs.
- Watches the detector's i_ref_setup output; any change restarts the settle-and-average sequence.

Parameters:
- BUS_WIDTH, 10: width of Q samples, q_measured and i_ref_setup.
- AVG_LOG2, 2: log2 of the number of samples averaged (default 4 samples).
- SETTLE_SAMPLES, 4: valid samples discarded after each i_ref_setup change, before accumulation starts.
- OUTLIER_DELTA, 20: rejection threshold; used only with Q_OUTLIER_REJECT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  run request; low forces IDLE.
- i_ref_setup  in  BUS_WIDTH  current reference setting from the instability detector.
- q_sample  in  BUS_WIDTH  raw Q reading.
- q_sample_valid  in  1  q_sample is valid this cycle.
- q_measured  out  BUS_WIDTH  averaged Q, registered.
- ready  out  1  q_measured is valid for the current i_ref_setup.

Behaviour:
- Reset values: state=IDLE, q_measured=0, ready=0, accumulator=0, counters=0, i_ref_last=0.
- Accumulator width is BUS_WIDTH+AVG_LOG2; it cannot overflow.
- Average = accumulator >> AVG_LOG2, truncated.
- i_ref_last is a register updated every cycle.
- Change event: i_ref_setup != i_ref_last while not in IDLE.
- States:
  - IDLE: ready=0, q_measured holds. enable=1 -> SETTLE with counters cleared.
  - SETTLE: each valid sample increments settle_cnt and is discarded. When settle_cnt reaches SETTLE_SAMPLES-1 on a valid sample -> ACCUM. SETTLE_SAMPLES=0 goes straight to ACCUM.
  - ACCUM: each valid sample is added and increments avg_cnt. On the 2**AVG_LOG2-th sample -> DONE. At that same edge, q_measured is loaded with (acc + sample) >> AVG_LOG2 and ready is set to 1. Latency: ready high one clock after the last sample is presented.
  - DONE: ready=1, q_measured held, samples ignored.
- Change event in SETTLE, ACCUM or DONE:
  - next edge: ready=0, accumulator and counters cleared, state -> SETTLE.
  - the sample in the change cycle is discarded and not counted.
  - q_measured keeps its old value; it is qualified by ready only.
- enable=0 in any state: next edge -> IDLE, ready=0, q_measured held.
- Change event and enable=0 in the same cycle: enable wins (IDLE).
- Samples with q_sample_valid=0 are never counted; gaps only stretch the sequence.
- rst mid-operation: immediate asynchronous return to all reset values.

Optional Feature:
- Macro: Q_OUTLIER_REJECT_EN.
- With the macro defined:
  - the first accumulated sample of each sequence is stored as the anchor;
  - any later ACCUM sample with |q_sample - anchor| > OUTLIER_DELTA is dropped: not added, not counted;
  - comparison is unsigned-safe, done on BUS_WIDTH+1 bits;
  - repeated rejections extend ACCUM indefinitely until enough good samples arrive.
- Without the macro: every valid ACCUM sample is accepted, and the anchor register and comparator are absent.

Decomposition:
- Shared package q_meas_pkg:
  - state enum (IDLE, SETTLE, ACCUM, DONE);
  - default BUS_WIDTH;
  - localparam helpers for accumulator and counter widths: $clog2(SETTLE_SAMPLES+1), AVG_LOG2+1.
- One natural sub-module: q_avg_accum, holding the accumulator, sample counter, and the outlier filter under the macro. The FSM and change detection stay in the top.

Test Plan (defaults except SETTLE_SAMPLES=2):
- Reset: assert rst between clock edges -> q_measured=0 and ready=0 immediately; both held through the next 3 edges.
- Basic average: enable=1, i_ref_setup=5, valid samples 100,101,102,103,104,105 on consecutive cycles -> 100,101 discarded; q_measured=103 (414>>2), ready=1 one clock after 105.
- Change mid-ACCUM: after samples 102,103 are accumulated, i_ref_setup 5->6 -> ready=0 (already 0), counters restart. Next samples 200,200,210,210,220,220 -> q_measured=215, ready=1.
- Valid gaps and DONE hold: same data as basic average with q_sample_valid toggling 1,0 -> q_measured=103; ready rises one clock after the sixth valid sample. Further samples leave q_measured=103.
- enable drop: clear enable in ACCUM -> IDLE next edge, ready=0, q_measured unchanged. Re-enable -> full settle+accum sequence repeats.
- Outlier: after settle, samples 100,100,200,100,100:
  - with Q_OUTLIER_REJECT_EN -> 200 rejected, q_measured=100;
  - without the macro -> q_measured=125 from 100,100,200,100.
